int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 68 ++++++
 tb/tb_int_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: 4-source edge-latched priority interrupt controller with config regs, one-shot int_req and vector output
module int_ctrl #(
  parameter int NUM_SRC    = 4,
  parameter int VEC_STRIDE = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               iret,
  input  logic               cfg_w_en,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_w_data,
  output logic [7:0]         cfg_r_data,
  output logic               int_req,
  output logic [7:0]         int_en,
  output logic [7:0]         int_vec
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [7:0] enable, vbase;
  logic [NUM_SRC-1:0] mask, pending, prev_src, edges, cand, clr;
  logic [1:0] active_src, pick;
  logic dispatch, in_service;
  always_comb begin
    edges = irq_src & ~prev_src;
    cand = pending & mask;
    pick = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
    dispatch = state == IDLE && enable[0] && |cand;
    clr = (cfg_w_en && cfg_addr == 2'd2 ? cfg_w_data[NUM_SRC-1:0] : '0) |
          (dispatch ? NUM_SRC'(1) << pick : '0);
  end
  always_comb begin
    state_n = state == IDLE ? (dispatch ? REQ : IDLE) :
              state == REQ  ? SERVICE : (iret ? IDLE : SERVICE);
  end
  always_comb begin
    in_service = state != IDLE;
    int_en = enable;
    cfg_r_data = cfg_addr == 2'd0 ? enable :
                 cfg_addr == 2'd1 ? {4'b0, mask} :
                 cfg_addr == 2'd2 ? {in_service, active_src, 1'b0, pending} : vbase;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      enable <= 8'h00;
      mask <= '0;
      pending <= '0;
      vbase <= 8'hF0;
      prev_src <= irq_src;
      active_src <= 2'd0;
      int_req <= 1'b0;
      int_vec <= 8'h00;
    end else begin
      state <= state_n;
      prev_src <= irq_src;
      pending <= (pending & ~clr) | edges;
      int_req <= dispatch;
      if (dispatch) begin
        active_src <= pick;
        int_vec <= vbase + 8'(pick * VEC_STRIDE);
      end
      if (cfg_w_en && cfg_addr == 2'd0) enable <= cfg_w_data;
      if (cfg_w_en && cfg_addr == 2'd1) mask <= cfg_w_data[NUM_SRC-1:0];
      if (cfg_w_en && cfg_addr == 2'd3) vbase <= cfg_w_data;
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed plus randomized checks of int_ctrl against a behavioural model
module tb_int_ctrl;
  logic clock = 0, reset = 1, iret = 0, cfg_w_en = 0, int_req;
  logic [3:0] irq_src = 0;
  logic [1:0] cfg_addr = 0;
  logic [7:0] cfg_w_data = 0, cfg_r_data, int_en, int_vec;
  int tests = 0, fails = 0;
  int_ctrl dut (
    .clock(clock), .reset(reset), .irq_src(irq_src), .iret(iret),
    .cfg_w_en(cfg_w_en), .cfg_addr(cfg_addr), .cfg_w_data(cfg_w_data),
    .cfg_r_data(cfg_r_data), .int_req(int_req), .int_en(int_en), .int_vec(int_vec)
  );
  always #5 clock = ~clock;
  logic [7:0] m_en, m_vb, m_vec, m_rd;
  logic [3:0] m_mask, m_pend, m_prev, e, cand;
  logic [1:0] m_act;
  logic m_req, mvalid = 0, disp;
  int m_ph, idx;
  task automatic chk(input string name, input logic [7:0] a, input logic [7:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, x, $time);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      m_en = 0; m_mask = 0; m_pend = 0; m_vb = 8'hF0; m_prev = irq_src;
      m_ph = 0; m_act = 0; m_req = 0; m_vec = 0; mvalid = 1;
    end else begin
      e = irq_src & ~m_prev;
      m_prev = irq_src;
      cand = m_pend & m_mask;
      idx = -1;
      for (int i = 3; i >= 0; i--) if (cand[i]) idx = i;
      disp = m_ph == 0 && m_en[0] && idx >= 0;
      if (cfg_w_en && cfg_addr == 2) m_pend &= ~cfg_w_data[3:0];
      if (disp) m_pend[idx] = 1'b0;
      m_pend |= e;
      m_req = 0;
      if (m_ph == 1) m_ph = 2;
      else if (m_ph == 2) begin
        if (iret) m_ph = 0;
      end else if (disp) begin
        m_ph = 1; m_req = 1; m_act = 2'(idx); m_vec = 8'(int'(m_vb) + idx * 4);
      end
      if (cfg_w_en && cfg_addr == 0) m_en = cfg_w_data;
      if (cfg_w_en && cfg_addr == 1) m_mask = cfg_w_data[3:0];
      if (cfg_w_en && cfg_addr == 3) m_vb = cfg_w_data;
    end
    #1;
    if (mvalid) begin
      m_rd = cfg_addr == 0 ? m_en : cfg_addr == 1 ? {4'b0, m_mask} :
             cfg_addr == 2 ? {m_ph != 0, m_act, 1'b0, m_pend} : m_vb;
      chk("model_int_req", {7'b0, int_req}, {7'b0, m_req});
      chk("model_int_vec", int_vec, m_vec);
      chk("model_int_en", int_en, m_en);
      chk("model_cfg_r_data", cfg_r_data, m_rd);
    end
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_w_en = 1; cfg_addr = a; cfg_w_data = d;
    tick();
    cfg_w_en = 0;
  endtask
  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] x);
    cfg_addr = a;
    #1;
    chk(name, cfg_r_data, x);
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  initial begin
    do_reset();
    chk("rst_req", {7'b0, int_req}, 8'h00);
    chk("rst_vec", int_vec, 8'h00);
    rd("rst_status", 2, 8'h00);
    rd("rst_vbase", 3, 8'hF0);
    wr(0, 8'h01); wr(1, 8'h0F);
    irq_src = 4'b0100; tick();
    chk("lat_no_req_yet", {7'b0, int_req}, 8'h00);
    rd("lat_pending", 2, 8'h04);
    tick();
    chk("src2_req", {7'b0, int_req}, 8'h01);
    chk("src2_vec", int_vec, 8'hF8);
    rd("src2_status", 2, 8'hC0);
    tick();
    chk("req_one_cycle", {7'b0, int_req}, 8'h00);
    iret = 1; tick(); iret = 0; irq_src = 0; tick();
    irq_src = 4'b1010; tick(); tick();
    chk("pair_first_req", {7'b0, int_req}, 8'h01);
    chk("pair_first_vec", int_vec, 8'hF4);
    tick();
    chk("pair_gap1", {7'b0, int_req}, 8'h00);
    tick();
    chk("pair_gap2", {7'b0, int_req}, 8'h00);
    iret = 1; tick(); iret = 0;
    chk("pair_gap3", {7'b0, int_req}, 8'h00);
    tick();
    chk("pair_second_req", {7'b0, int_req}, 8'h01);
    chk("pair_second_vec", int_vec, 8'hFC);
    iret = 1; tick();
    rd("iret_in_req_ignored", 2, 8'hE0);
    tick(); iret = 0; irq_src = 0; tick();
    do_reset();
    wr(0, 8'h01);
    irq_src = 4'b0001; tick(); tick();
    chk("masked_no_req", {7'b0, int_req}, 8'h00);
    rd("masked_status", 2, 8'h01);
    cfg_w_en = 1; cfg_addr = 1; cfg_w_data = 8'h01; tick(); cfg_w_en = 0;
    chk("unmask_not_yet", {7'b0, int_req}, 8'h00);
    tick();
    chk("unmask_req", {7'b0, int_req}, 8'h01);
    chk("unmask_vec", int_vec, 8'hF0);
    tick(); iret = 1; tick(); iret = 0;
    wr(1, 8'h00);
    irq_src = 4'b0011; cfg_w_en = 1; cfg_addr = 2; cfg_w_data = 8'h02; tick(); cfg_w_en = 0;
    rd("set_beats_clear", 2, 8'h02);
    wr(2, 8'h02);
    rd("w1c_clears", 2, 8'h00);
    irq_src = 0; tick();
    wr(1, 8'h0F);
    irq_src = 4'b0100; tick(); tick(); tick();
    irq_src = 4'b0111; tick();
    rd("svc_pending3", 2, 8'hC3);
    reset = 1; cfg_w_en = 1; cfg_addr = 0; cfg_w_data = 8'hFF; iret = 1; tick();
    reset = 0; cfg_w_en = 0; tick(); iret = 0;
    chk("midrst_req", {7'b0, int_req}, 8'h00);
    chk("midrst_vec", int_vec, 8'h00);
    rd("midrst_en", 0, 8'h00);
    rd("midrst_mask", 1, 8'h00);
    rd("midrst_status", 2, 8'h00);
    rd("midrst_vbase", 3, 8'hF0);
    wr(0, 8'h01); wr(1, 8'h0F); wr(3, 8'hFE);
    irq_src = 0; tick();
    irq_src = 4'b0010; tick(); tick();
    chk("wrap_req", {7'b0, int_req}, 8'h01);
    chk("wrap_vec", int_vec, 8'h02);
    tick(); iret = 1; tick(); iret = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
      iret = $urandom_range(0, 5) == 0;
      cfg_w_en = $urandom_range(0, 5) == 0;
      cfg_addr = 2'($urandom);
      cfg_w_data = 8'($urandom);
      if (cfg_addr == 0 && $urandom_range(0, 3) != 0) cfg_w_data[0] = 1'b1;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
